// File: rtl/mesm6_memarb.sv
`default_nettype none
// ============================================================================
// Module   : mesm6_memarb
// Brief    : Round-robin arbiter of core fetch/data requests onto one memory port
// Revision : 1.0
// ============================================================================
module mesm6_memarb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_fetch,
  input  logic [14:0] ibus_addr,
  output logic [47:0] ibus_input,
  output logic        ibus_done,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [14:0] dbus_addr,
  input  logic [47:0] dbus_output,
  output logic [47:0] dbus_input,
  output logic        dbus_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [47:0] mem_wdata,
  input  logic [47:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] C_LAST_CNT = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic       r_grant_data;
  logic       r_last_fetch;
  logic [7:0] r_cnt;

  logic w_dreq;
  logic w_pick_data;

  // Data wins a tie only when fetch held the previous grant
  assign w_dreq      = dbus_read | dbus_write;
  assign w_pick_data = w_dreq & (~ibus_fetch | r_last_fetch);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant_data <= 1'b0;
      r_last_fetch <= 1'b1;
      r_cnt        <= 8'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 15'd0;
      mem_wdata    <= 48'd0;
      ibus_done    <= 1'b0;
      dbus_done    <= 1'b0;
      bus_error    <= 1'b0;
      ibus_input   <= 48'd0;
      dbus_input   <= 48'd0;
    end else begin
      ibus_done <= 1'b0;
      dbus_done <= 1'b0;
      bus_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ibus_fetch | w_dreq) begin
            r_state      <= S_ACCESS;
            mem_req      <= 1'b1;
            r_cnt        <= 8'd0;
            r_grant_data <= w_pick_data;
            r_last_fetch <= ~w_pick_data;
            if (w_pick_data) begin
              mem_we    <= dbus_write;
              mem_addr  <= dbus_addr;
              mem_wdata <= dbus_output;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= ibus_addr;
              mem_wdata <= 48'd0;
            end
          end
        end
        S_ACCESS: begin
          // An ack in the timeout cycle still wins over the abort
          if (mem_ack || (r_cnt == C_LAST_CNT)) begin
            r_state   <= S_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            bus_error <= ~mem_ack;
            if (r_grant_data) begin
              dbus_done <= 1'b1;
              if (!mem_we) dbus_input <= mem_ack ? mem_rdata : 48'd0;
            end else begin
              ibus_done <= 1'b1;
              ibus_input <= mem_ack ? mem_rdata : 48'd0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mesm6_memarb.md
MESM6_MEMARB -- requirements
Module: mesm6_memarb

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles mem_req is held without mem_ack before abort (range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock, all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port ibus_fetch, input, 1, core instruction-fetch request (level, held until ibus_done).
REQ-005 The block SHALL have port ibus_addr, input, 15, fetch word address.
REQ-006 The block SHALL have port ibus_input, output, 48, fetched instruction word.
REQ-007 The block SHALL have port ibus_done, output, 1, one-cycle fetch-completion pulse.
REQ-008 The block SHALL have ports dbus_read and dbus_write, input, 1 each, core data read and write requests (level, held until dbus_done).
REQ-009 The block SHALL have port dbus_addr, input, 15, data word address.
REQ-010 The block SHALL have port dbus_output, input, 48, core write data.
REQ-011 The block SHALL have port dbus_input, output, 48, data read result.
REQ-012 The block SHALL have port dbus_done, output, 1, one-cycle data-completion pulse.
REQ-013 The block SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 15), mem_wdata (output, 48): the single shared memory port request.
REQ-014 The block SHALL have ports mem_rdata (input, 48) and mem_ack (input, 1): memory read data and completion, valid in the same cycle.
REQ-015 The block SHALL have port bus_error, output, 1, one-cycle pulse on a timed-out access.

Function
REQ-016 The block SHALL implement states IDLE, ACCESS, RESP.
REQ-017 In IDLE, when at least one request is high, the block SHALL grant one requester and enter ACCESS next cycle with mem_req=1 and mem_addr/mem_we/mem_wdata registered from the granted requester.
REQ-018 Arbitration SHALL be round-robin between fetch and data: on simultaneous requests, the requester not granted last wins; after reset, data wins first.
REQ-019 When dbus_read and dbus_write are both high, the block SHALL perform a write only (mem_we=1) and complete it with dbus_done.
REQ-020 mem_req, mem_we, mem_addr, mem_wdata SHALL stay constant throughout ACCESS regardless of changes on core request inputs.
REQ-021 In ACCESS, mem_ack=1 SHALL deassert mem_req next cycle and move to RESP; mem_ack is ignored while mem_req=0.
REQ-022 On read completion, mem_rdata SHALL be latched into ibus_input or dbus_input (per grant) on the mem_ack edge; the other output SHALL keep its previous value; both hold until their next read completes.
REQ-023 In RESP the block SHALL assert exactly one of ibus_done/dbus_done for exactly one cycle, then return to IDLE.
REQ-024 Requests SHALL NOT be sampled in RESP (the core's request is still high that cycle); minimum issue-to-issue spacing is therefore 3 cycles.
REQ-025 Latency: request first high at cycle 0, mem_ack at cycle k (k>=1) -> done at cycle k+1.
REQ-026 An ACCESS cycle counter (8-bit, cleared on ACCESS entry) SHALL abort when mem_req has been high TIMEOUT cycles without mem_ack: mem_req drops, RESP follows with the done pulse plus bus_error=1 for the same cycle, and a timed-out read loads 0 into its data output.
REQ-027 mem_ack arriving in the same cycle as the timeout SHALL count as a normal completion (no bus_error).
REQ-028 A request deasserted by the core while in ACCESS SHALL NOT abort the access; done SHALL still be pulsed.

Reset
REQ-029 reset SHALL force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ibus_done=0, dbus_done=0, bus_error=0, ibus_input=0, dbus_input=0, counter=0, last-grant=fetch (so data wins first).
REQ-030 reset asserted mid-ACCESS SHALL drop mem_req on the next edge with no done pulse; a later mem_ack SHALL be ignored.

Verification
REQ-031 Fetch only: ibus_fetch=1, ibus_addr=0o100, mem_ack at cycle 3 with rdata=0x123456789ABC -> mem_req cycles 1-3, ibus_done at cycle 4, ibus_input=0x123456789ABC.
REQ-032 Simultaneous fetch and read after reset: data granted first, fetch second; dbus_done precedes ibus_done, never in the same cycle.
REQ-033 Write: dbus_write=1, dbus_addr=0o7777, dbus_output=0xFFFF00000001 -> mem_we=1, mem_wdata matches, dbus_done one cycle after mem_ack, dbus_input unchanged.
REQ-034 Timeout with TIMEOUT=4, no mem_ack: mem_req high exactly 4 cycles, then dbus_done and bus_error pulse together, dbus_input=0.
REQ-035 Reset at the 2nd ACCESS cycle, then mem_ack pulse -> mem_req=0 after the reset edge, no done pulse, all outputs at reset values.
REQ-036 Back-to-back fetches, each acked in its first ACCESS cycle: done pulses every 3 cycles, alternating grant when a data request is also pending.
